// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 2-bit-opcode datapath: steps each instruction through
// fetch/decode/execute/memory/writeback on a shared memory port, counts retirements, traps stalls.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Branch,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       ALUOp,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_WB_R   = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_WB_MEM = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ERROR  = 4'd10;

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT - 1);

  logic [3:0]     state;
  logic [3:0]     state_next;
  logic [WCW-1:0] wait_cnt;
  logic           mem_state;
  logic           timeout;
  logic           retire;
  logic [3:0]     after_retire;

  assign mem_state    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout      = mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);
  assign retire       = (state == S_WB_R) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                        ((state == S_MEM_WR) && mem_ready);
  assign after_retire = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (timeout) state_next = S_ERROR;
      S_DECODE: case (opcode)
                  2'b00:   state_next = S_EXEC_R;
                  2'b11:   state_next = S_BRANCH;
                  default: state_next = S_ADDR;
                endcase
      S_EXEC_R: state_next = S_WB_R;
      S_WB_R:   state_next = after_retire;
      S_ADDR:   state_next = (opcode == 2'b01) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
                else if (timeout) state_next = S_ERROR;
      S_WB_MEM: state_next = after_retire;
      S_MEM_WR: if (mem_ready) state_next = after_retire;
                else if (timeout) state_next = S_ERROR;
      S_BRANCH: state_next = after_retire;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
  end

  // A memory state is never re-entered directly from itself after a completed access,
  // so clearing whenever not stalling also clears on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (mem_state && !mem_ready) ? wait_cnt + 1'b1 : '0;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUOp    = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC_R: ALUOp = 2'b10;
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        ALUOp    = 2'b10;
      end
      S_ADDR: ALUSrc = 1'b1;
      S_MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        ALUSrc  = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        ALUSrc   = 1'b1;
      end
      S_BRANCH: begin
        Branch  = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = zero;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE) && (state != S_ERROR);
  assign error = (state == S_ERROR);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are queued when
// inputs are driven and popped at the falling edge for comparison.
module tb_multicycle_control;

  localparam int CW = 8;

  localparam int IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, WB_R = 4, ADDR = 5,
                 MEM_RD = 6, WB_MEM = 7, MEM_WR = 8, BRANCH = 9, ERROR = 10;

  logic          clk = 1'b0;
  logic          rst, run, zero, mem_ready;
  logic [1:0]    opcode;
  logic          mem_req, IorD, IRWrite, PCWrite, PCSrc, Branch, MemtoReg, MemRead;
  logic          MemWrite, ALUSrc, RegWrite, RegDst, busy, error;
  logic [1:0]    ALUOp;
  logic [CW-1:0] instr_count;
  logic [15:0]   obs;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .busy(busy),
    .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, IorD, IRWrite, PCWrite, PCSrc, Branch, MemtoReg, MemRead,
                MemWrite, ALUSrc, RegWrite, RegDst, ALUOp, busy, error};

  // Expected control word for a state, written straight from the state output table.
  function automatic logic [15:0] expo(input int s, input logic r, input logic z);
    logic mq, iod, irw, pcw, pcs, br, m2r, mr, mw, as, rw, rd, bz, er;
    logic [1:0] op;
    {mq, iod, irw, pcw, pcs, br, m2r, mr, mw, as, rw, rd, bz, er} = '0;
    op = 2'b00;
    bz = (s != IDLE) && (s != ERROR);
    case (s)
      FETCH:  begin mq = 1; mr = 1; irw = r; pcw = r; end
      EXEC_R: op = 2'b10;
      WB_R:   begin rw = 1; rd = 1; op = 2'b10; end
      ADDR:   as = 1;
      MEM_RD: begin mq = 1; mr = 1; iod = 1; as = 1; end
      WB_MEM: begin rw = 1; m2r = 1; end
      MEM_WR: begin mq = 1; mw = 1; iod = 1; as = 1; end
      BRANCH: begin br = 1; op = 2'b01; pcs = 1; pcw = z; end
      ERROR:  er = 1;
      default: ;
    endcase
    return {mq, iod, irw, pcw, pcs, br, m2r, mr, mw, as, rw, rd, op, bz, er};
  endfunction

  // One clock cycle with the current inputs; the expected outputs for it are queued first.
  task automatic step(input string tag, input int s);
    logic [15:0] e, got;
    string t;
    exp_q.push_back(expo(s, mem_ready, zero));
    tag_q.push_back(tag);
    @(negedge clk);
    got = obs;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", t, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] e);
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; run = 1'b1; opcode = 2'b00; zero = 1'b0; mem_ready = 1'b1;

    // Reset with run high, R-type stream
    do_reset();
    chk("reset_count", 32'(instr_count), 0);
    step("rst_idle", IDLE);
    for (int i = 0; i < 3; i++) begin
      step("r_fetch", FETCH);
      step("r_decode", DECODE);
      step("r_exec", EXEC_R);
      step("r_wb", WB_R);
    end
    chk("r_count3", 32'(instr_count), 3);

    // Load with three not-ready cycles in MEM_RD
    opcode = 2'b01;
    step("ld_fetch", FETCH);
    step("ld_decode", DECODE);
    step("ld_addr", ADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ld_memrd_wait", MEM_RD);
    mem_ready = 1'b1;
    step("ld_memrd_rdy", MEM_RD);
    step("ld_wbmem", WB_MEM);
    chk("ld_count", 32'(instr_count), 4);

    // Branch taken then not taken
    opcode = 2'b11;
    zero = 1'b1;
    step("br1_fetch", FETCH);
    step("br1_decode", DECODE);
    step("br1_branch_z1", BRANCH);
    zero = 1'b0;
    step("br0_fetch", FETCH);
    step("br0_decode", DECODE);
    step("br0_branch_z0", BRANCH);
    chk("br_count", 32'(instr_count), 6);

    // Store with ready on the last permitted wait cycle
    opcode = 2'b10;
    step("stl_fetch", FETCH);
    step("stl_decode", DECODE);
    step("stl_addr", ADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("stl_memwr_wait", MEM_WR);
    mem_ready = 1'b1;
    step("stl_memwr_limit_rdy", MEM_WR);
    chk("stl_count", 32'(instr_count), 7);

    // Load with run dropped while waiting: completes, then IDLE
    opcode = 2'b01;
    step("ldr_fetch", FETCH);
    step("ldr_decode", DECODE);
    step("ldr_addr", ADDR);
    mem_ready = 1'b0;
    run = 1'b0;
    step("ldr_memrd_wait", MEM_RD);
    mem_ready = 1'b1;
    step("ldr_memrd_rdy", MEM_RD);
    step("ldr_wbmem", WB_MEM);
    step("ldr_idle", IDLE);
    step("ldr_idle_hold", IDLE);
    chk("ldr_count", 32'(instr_count), 8);

    // Store with memory stalled: trap after 16 cycles in MEM_WR
    run = 1'b1;
    opcode = 2'b10;
    step("to_idle", IDLE);
    step("to_fetch", FETCH);
    step("to_decode", DECODE);
    step("to_addr", ADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("to_memwr_wait", MEM_WR);
    step("to_error", ERROR);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("to_error_hold", ERROR);
    chk("to_count_kept", 32'(instr_count), 8);
    do_reset();
    chk("to_rst_error", 32'(error), 0);
    chk("to_rst_count", 32'(instr_count), 0);

    // Counter wrap via branches
    opcode = 2'b11;
    step("wr_idle", IDLE);
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      step("wr_fetch", FETCH);
      step("wr_decode", DECODE);
      step("wr_branch", BRANCH);
    end
    chk("wr_allones", 32'(instr_count), (1 << CW) - 1);
    step("wr_fetch_last", FETCH);
    step("wr_decode_last", DECODE);
    step("wr_branch_last", BRANCH);
    chk("wr_zero", 32'(instr_count), 0);

    // Reset during a stalled FETCH
    opcode = 2'b00;
    mem_ready = 1'b0;
    step("rf_fetch_wait", FETCH);
    rst = 1'b1;
    step("rf_fetch_rst", FETCH);
    chk("rf_mem_req", 32'(mem_req), 0);
    chk("rf_busy", 32'(busy), 0);
    rst = 1'b0;
    run = 1'b0;
    step("rf_idle", IDLE);
    chk("rf_count", 32'(instr_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
